// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;
    localparam int DW_DEF      = 16;
    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie the port not served last wins.
module arb_rr2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter (CPU / DMA) with round-robin tie break and
// an access timeout; every output comes straight from a register.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          Clock_Puls,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          Wr0,
    input  logic [DW-1:0] Addr0,
    input  logic [DW-1:0] WData0,
    input  logic          Req1,
    input  logic          Wr1,
    input  logic [DW-1:0] Addr1,
    input  logic [DW-1:0] WData1,
    input  logic          Mem_Ready,
    input  logic [DW-1:0] Mem_RData,
    output logic [DW-1:0] Mem_Addr,
    output logic [DW-1:0] Mem_WData,
    output logic          Mem_Rd,
    output logic          Mem_Wr,
    output logic          Gnt0,
    output logic          Gnt1,
    output logic          Ack0,
    output logic          Ack1,
    output logic [DW-1:0] RData,
    output logic          Err,
    output logic          Busy
);
    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lwr_q, lwr_d;
    logic [DW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         ack_q, ack_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [1:0]         win;
    logic               sel_wr;

    arb_rr2 u_pick (
        .req0_i (Req0),
        .req1_i (Req1),
        .last_i (ptr_q),
        .gnt_o  (win)
    );

    assign sel_wr = win[1] ? Wr1 : Wr0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lwr_d   = lwr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt_d   = gnt_q;
        ack_d   = 2'b00;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win != 2'b00) begin
                    state_d = ST_ACCESS;
                    gnt_d   = win;
                    ptr_d   = win[1];
                    cnt_d   = '0;
                    lwr_d   = sel_wr;
                    addr_d  = win[1] ? Addr1  : Addr0;
                    wdata_d = win[1] ? WData1 : WData0;
                    rd_d    = ~sel_wr;
                    wr_d    = sel_wr;
                end
            end
            ST_ACCESS: begin
                // A ready in the last allowed cycle still completes normally
                if (Mem_Ready) begin
                    state_d = ST_DONE;
                    ack_d   = gnt_q;
                    if (!lwr_q) rdata_d = Mem_RData;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rd_d  = ~lwr_q;
                    wr_d  = lwr_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock_Puls) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b1;
            cnt_q   <= '0;
            lwr_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lwr_q   <= lwr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign Mem_Addr  = addr_q;
    assign Mem_WData = wdata_q;
    assign Mem_Rd    = rd_q;
    assign Mem_Wr    = wr_q;
    assign Gnt0      = gnt_q[0];
    assign Gnt1      = gnt_q[1];
    assign Ack0      = ack_q[0];
    assign Ack1      = ack_q[1];
    assign RData     = rdata_q;
    assign Err       = err_q;
    assign Busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: the driver predicts each
// transaction's outcome, an independent monitor checks it on the bus.
module tb_mem_arbiter;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          Clock_Puls = 1'b0;
    logic          Reset;
    logic          Req0, Wr0, Req1, Wr1, Mem_Ready;
    logic [DW-1:0] Addr0, WData0, Addr1, WData1, Mem_RData;
    logic [DW-1:0] Mem_Addr, Mem_WData, RData;
    logic          Mem_Rd, Mem_Wr, Gnt0, Gnt1, Ack0, Ack1, Err, Busy;

    mem_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
        .Clock_Puls (Clock_Puls), .Reset (Reset),
        .Req0 (Req0), .Wr0 (Wr0), .Addr0 (Addr0), .WData0 (WData0),
        .Req1 (Req1), .Wr1 (Wr1), .Addr1 (Addr1), .WData1 (WData1),
        .Mem_Ready (Mem_Ready), .Mem_RData (Mem_RData),
        .Mem_Addr (Mem_Addr), .Mem_WData (Mem_WData),
        .Mem_Rd (Mem_Rd), .Mem_Wr (Mem_Wr),
        .Gnt0 (Gnt0), .Gnt1 (Gnt1), .Ack0 (Ack0), .Ack1 (Ack1),
        .RData (RData), .Err (Err), .Busy (Busy)
    );

    always #5 Clock_Puls = ~Clock_Puls;

    typedef struct {
        int            port;
        bit            wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            err;
        int            strobes;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 0;
    int            strobe_cnt = 0;
    bit            prev_strobe = 0;

    // Reference state: pending requests per port, last served port, RData
    bit            p_vld [2];
    bit            p_wr  [2];
    logic [DW-1:0] p_addr[2];
    logic [DW-1:0] p_wd  [2];
    int            last;
    logic [DW-1:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic drive_ports();
        Req0 = p_vld[0]; Wr0 = p_wr[0]; Addr0 = p_addr[0]; WData0 = p_wd[0];
        Req1 = p_vld[1]; Wr1 = p_wr[1]; Addr1 = p_addr[1]; WData1 = p_wd[1];
    endtask

    task automatic set_req(input int p, input bit wr, input logic [DW-1:0] a, input logic [DW-1:0] d);
        p_vld[p] = 1'b1; p_wr[p] = wr; p_addr[p] = a; p_wd[p] = d;
    endtask

    // One arbitration round; waits >= TO means memory never answers.
    task automatic issue(input int waits, input logic [DW-1:0] mdata, input bit scramble, input bit drop);
        int   w;
        exp_t e;
        drive_ports();
        if (!p_vld[0] && !p_vld[1]) begin
            Mem_Ready = 1'($urandom);
            @(posedge Clock_Puls); #1;
            return;
        end
        w = (p_vld[0] && p_vld[1]) ? ((last == 0) ? 1 : 0) : (p_vld[0] ? 0 : 1);
        last      = w;
        e.port    = w;
        e.wr      = p_wr[w];
        e.addr    = p_addr[w];
        e.wdata   = p_wd[w];
        e.err     = (waits >= TO);
        e.strobes = e.err ? TO : waits + 1;
        e.rdata   = e.err ? '0 : (p_wr[w] ? m_rdata : mdata);
        m_rdata   = e.rdata;
        sb.push_back(e);
        @(posedge Clock_Puls); #1;
        if (scramble) begin
            p_wr[w] = 1'($urandom); p_addr[w] = DW'($urandom); p_wd[w] = DW'($urandom);
        end
        if (drop) p_vld[w] = 1'b0;
        drive_ports();
        for (int k = 0; k < e.strobes; k++) begin
            Mem_Ready = (k == waits);
            Mem_RData = (k == waits) ? mdata : DW'($urandom);
            @(posedge Clock_Puls); #1;
        end
        Mem_Ready = 1'($urandom); Mem_RData = DW'($urandom);
        @(posedge Clock_Puls); #1;
        p_vld[w] = 1'b0;
        drive_ports();
        Mem_Ready = 1'($urandom); Mem_RData = DW'($urandom);
    endtask

    always @(negedge Clock_Puls) begin
        if (!mon_en) begin
            strobe_cnt  = 0;
            prev_strobe = 0;
        end else begin
            if (Mem_Rd || Mem_Wr) begin
                strobe_cnt++;
                if (sb.size() > 0) begin
                    chk("strobe_dir", {30'd0, Mem_Rd, Mem_Wr}, sb[0].wr ? 2'b01 : 2'b10);
                    chk("mem_addr", Mem_Addr, sb[0].addr);
                    if (sb[0].wr) chk("mem_wdata", Mem_WData, sb[0].wdata);
                    chk("gnt_access", {Gnt1, Gnt0}, onehot(sb[0].port));
                end else begin
                    chk("strobe_no_req", {Mem_Rd, Mem_Wr}, 2'b00);
                end
            end
            if (Ack0 || Ack1) begin
                if (sb.size() == 0) begin
                    chk("ack_no_req", {Ack1, Ack0}, 2'b00);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_port", {Ack1, Ack0}, onehot(mon_e.port));
                    chk("gnt_done", {Gnt1, Gnt0}, onehot(mon_e.port));
                    chk("rdata", RData, mon_e.rdata);
                    chk("err", Err, mon_e.err);
                    chk("strobe_cycles", strobe_cnt, mon_e.strobes);
                    chk("ack_after_strobe", prev_strobe, 1);
                    chk("strobes_low_done", {Mem_Rd, Mem_Wr}, 2'b00);
                end
                strobe_cnt = 0;
            end else begin
                chk("err_without_ack", Err, 0);
            end
            chk("busy_vs_gnt", Busy, Gnt0 | Gnt1);
            prev_strobe = Mem_Rd || Mem_Wr;
        end
    end

    task automatic random_round();
        int waits;
        for (int p = 0; p < 2; p++)
            if (!p_vld[p] && $urandom_range(0, 2) != 0)
                set_req(p, 1'($urandom), DW'($urandom), DW'($urandom));
        waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
        issue(waits, DW'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            p_vld[p] = 1'b1; p_wr[p] = 1'b1; p_addr[p] = '1; p_wd[p] = '1;
        end
        drive_ports();
        Reset = 1'b1; Mem_Ready = 1'b1; Mem_RData = '1;
        repeat (3) @(posedge Clock_Puls);
        @(negedge Clock_Puls);
        chk("rst_ctrl", {24'd0, Mem_Rd, Mem_Wr, Gnt0, Gnt1, Ack0, Ack1, Err, Busy}, 0);
        chk("rst_addr", Mem_Addr, 0);
        chk("rst_wdata", Mem_WData, 0);
        chk("rst_rdata", RData, 0);
        @(posedge Clock_Puls); #1;
        Reset = 1'b0; Mem_Ready = 1'b0;
        p_vld[0] = 1'b0; p_vld[1] = 1'b0;
        drive_ports();
        last = 1; m_rdata = '0; mon_en = 1'b1;

        // Simultaneous requests from reset: port 0 wins first, then alternate
        set_req(0, 1'b0, 16'h0100, 16'h0000);
        set_req(1, 1'b0, 16'h0200, 16'h0000);
        for (int r = 0; r < 6; r++) begin
            issue(0, DW'(16'hA000 + r), 1'b0, 1'b0);
            if (r < 5) begin
                if (!p_vld[0]) set_req(0, 1'b0, DW'(16'h0100 + r), 16'h0000);
                if (!p_vld[1]) set_req(1, 1'b0, DW'(16'h0200 + r), 16'h0000);
            end
        end
        issue(1, 16'h5555, 1'b0, 1'b0);

        set_req(0, 1'b0, 16'h0010, 16'h0000);
        issue(0, 16'h1234, 1'b0, 1'b0);
        set_req(1, 1'b1, 16'h00FF, 16'hBEEF);
        issue(3, 16'hDEAD, 1'b1, 1'b0);
        set_req(0, 1'b0, 16'h0042, 16'h0000);
        issue(TO, 16'hFFFF, 1'b0, 1'b0);
        set_req(0, 1'b0, 16'h0077, 16'h0000);
        issue(2, 16'h7777, 1'b0, 1'b1);
        set_req(1, 1'b0, 16'h0088, 16'h0000);
        issue(0, 16'h8888, 1'b0, 1'b0);

        for (int r = 0; r < 200; r++) random_round();

        // Reset in the second ACCESS cycle: abort with no acknowledge
        while (p_vld[0] || p_vld[1]) issue(0, DW'($urandom), 1'b0, 1'b0);
        mon_en = 1'b0;
        set_req(0, 1'b0, 16'h0AAA, 16'h0000);
        drive_ports();
        Mem_Ready = 1'b0;
        @(posedge Clock_Puls); #1;
        @(posedge Clock_Puls); #1;
        Reset = 1'b1; Mem_Ready = 1'b1; Req1 = 1'b1;
        @(posedge Clock_Puls); #1;
        Reset = 1'b0; Mem_Ready = 1'b0;
        p_vld[0] = 1'b0; p_vld[1] = 1'b0;
        drive_ports();
        last = 1; m_rdata = '0;
        @(negedge Clock_Puls);
        chk("rst_mid_ctrl", {27'd0, Mem_Rd, Mem_Wr, Gnt0, Gnt1, Busy}, 0);
        chk("rst_mid_rdata", RData, 0);
        for (int c = 0; c < 5; c++) begin
            chk("rst_mid_no_ack", {Ack1, Ack0}, 2'b00);
            Mem_Ready = 1'($urandom);
            @(negedge Clock_Puls);
        end
        @(posedge Clock_Puls); #1;
        Mem_Ready = 1'b0;
        mon_en = 1'b1;

        set_req(0, 1'b1, 16'h0300, 16'h0301);
        set_req(1, 1'b1, 16'h0400, 16'h0401);
        issue(1, 16'h0000, 1'b0, 1'b0);
        issue(0, 16'h0000, 1'b0, 1'b0);
        for (int r = 0; r < 30; r++) random_round();

        repeat (4) @(posedge Clock_Puls);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
